// File: rtl/mem_copy_master_if.sv
// Memory bus between the copy engine and the data memory.
// The memory answers reads combinationally from mem_addr/mem_rd and
// performs writes on the rising clock edge while mem_wr is high.
//   master: drives mem_rd, mem_wr, mem_addr, mem_wdata; receives mem_rdata
//   slave : the data memory side of the same bus
interface mem_copy_master_if;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output mem_rd,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_copy_master.sv
// Simple DMA engine: copies word_cnt 32-bit words from src_addr to dst_addr,
// one READ cycle followed by one WRITE cycle per word, in ascending order.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   start              copy request, only honoured in IDLE
//   src_addr/dst_addr  byte addresses of the first source/destination word
//   word_cnt           number of words to copy
//   abort              stop the copy in progress (READ/WRITE only)
//   busy               high during READ and WRITE
//   done               one-cycle completion pulse
//   err                misalignment or abort; held until the next accepted start
//   words_done         words written by the current or last copy
//   bus                memory master port (rd/wr/addr/wdata/rdata)
module mem_copy_master #(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           src_addr,
  input  logic [31:0]           dst_addr,
  input  logic [CNT_W-1:0]      word_cnt,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CNT_W-1:0]      words_done,
  mem_copy_master_if.master     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [31:0]       src_ptr_r;
  logic [31:0]       dst_ptr_r;
  logic [CNT_W-1:0]  remaining_r;
  logic [CNT_W-1:0]  words_done_r;
  logic [31:0]       buf_r;
  logic [31:0]       addr_r;
  logic              err_r;
  logic              misalign_s;

  assign misalign_s = (src_addr[1:0] != 2'd0) || (dst_addr[1:0] != 2'd0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; misalignment is checked before the zero-count case.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (misalign_s) begin
            state_s = DONE;
          end else if (word_cnt == {CNT_W{1'b0}}) begin
            state_s = DONE;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        if (abort) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_s = DONE;
        end else if (remaining_r == {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_s = DONE;
        end else begin
          state_s = READ;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Datapath: pointers, counters, data buffer and the registered bus address.
  // addr_r is loaded one cycle ahead with the address the next state needs,
  // so it is stable through each strobe and holds its value while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr_r    <= 32'd0;
      dst_ptr_r    <= 32'd0;
      remaining_r  <= {CNT_W{1'b0}};
      words_done_r <= {CNT_W{1'b0}};
      buf_r        <= 32'd0;
      addr_r       <= 32'd0;
      err_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            src_ptr_r    <= src_addr;
            dst_ptr_r    <= dst_addr;
            remaining_r  <= word_cnt;
            words_done_r <= {CNT_W{1'b0}};
            err_r        <= misalign_s;
            if (state_s == READ) begin
              addr_r <= src_addr;
            end
          end
        end
        READ: begin
          if (abort) begin
            // The word just read is dropped.
            err_r <= 1'b1;
          end else begin
            buf_r     <= bus.mem_rdata;
            src_ptr_r <= src_ptr_r + 32'd4;
            addr_r    <= dst_ptr_r;
          end
        end
        WRITE: begin
          // The write strobe is already out this cycle, so the word counts
          // even when abort is high.
          dst_ptr_r    <= dst_ptr_r + 32'd4;
          remaining_r  <= remaining_r - {{(CNT_W-1){1'b0}}, 1'b1};
          words_done_r <= words_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (abort) begin
            err_r <= 1'b1;
          end
          if (state_s == READ) begin
            addr_r <= src_ptr_r;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Strobes and status decode from the registered state only.
  assign bus.mem_rd    = (state_r == READ);
  assign bus.mem_wr    = (state_r == WRITE);
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = buf_r;
  assign busy          = (state_r == READ) || (state_r == WRITE);
  assign done          = (state_r == DONE);
  assign err           = err_r;
  assign words_done    = words_done_r;

endmodule

// File: tb/tb_mem_copy_master.sv
// Scoreboard bench for mem_copy_master: a word-level copy model predicts the
// bus transactions, the completion status and the final memory contents.
module tb_mem_copy_master;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [31:0]      src_addr = 32'd0;
  logic [31:0]      dst_addr = 32'd0;
  logic [CNT_W-1:0] word_cnt = '0;
  logic             busy, done, err;
  logic [CNT_W-1:0] words_done;

  mem_copy_master_if bus ();

  mem_copy_master #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .word_cnt(word_cnt), .abort(abort), .busy(busy),
    .done(done), .err(err), .words_done(words_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: 256 words, aliased on addr[9:2]; combinational read, clocked write.
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic        fill_en = 1'b1;
  logic [7:0]  fill_idx = 8'd0;
  logic [31:0] fill_data = 32'd0;

  always @(posedge clk) begin
    if (fill_en) mem[fill_idx] <= fill_data;
    else if (bus.mem_wr) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = bus.mem_rd ? mem[bus.mem_addr[9:2]] : 32'd0;

  typedef struct {
    int               kind;   // 0 read, 1 write, 2 done
    logic [31:0]      addr;
    logic [31:0]      data;
    logic             err;
    logic [CNT_W-1:0] wd;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   done_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  // Monitor: every strobe or done pulse must match the next expected event.
  always @(negedge clk) begin
    exp_t e;
    int   k;
    if (!reset && (bus.mem_rd || bus.mem_wr || done)) begin
      k = bus.mem_rd ? 0 : (bus.mem_wr ? 1 : 2);
      chk("busy_decode", 64'(busy), 64'(k != 2));
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 64'(k), 64'd99);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", 64'(k), 64'(e.kind));
        if (k == e.kind) begin
          case (k)
            0: chk("rd_addr", 64'(bus.mem_addr), 64'(e.addr));
            1: begin
              chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
              chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
            end
            default: begin
              chk("done_err", 64'(err), 64'(e.err));
              chk("done_words", 64'(words_done), 64'(e.wd));
              chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
          endcase
        end
      end
      if (k == 2) done_count++;
    end
  end

  // One copy: model it word by word, then drive start (and optionally abort
  // in cycle ab after the start edge, 1 = first READ).
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int ab, input bit junk, input bit sa);
    int n_rd, n_wr, lat, c, dc0, t, cy;
    logic e_err;
    logic [31:0] w, a;
    exp_t e;
    if (s[1:0] != 2'd0 || d[1:0] != 2'd0) begin
      n_rd = 0; n_wr = 0; lat = 0; e_err = 1'b1;
    end else if (n == 0) begin
      n_rd = 0; n_wr = 0; lat = 0; e_err = 1'b0;
    end else if (ab == 0 || ab > 2 * n) begin
      n_rd = n; n_wr = n; lat = 2 * n; e_err = 1'b0;
    end else begin
      n_rd = (ab + 1) / 2; n_wr = ab / 2; lat = ab; e_err = 1'b1;
    end
    for (int i = 0; i < n_rd; i++) begin
      a = s + 32'(4 * i);
      e.kind = 0; e.addr = a; e.data = 32'd0; e.err = 1'b0; e.wd = '0; e.cyc = 0;
      exp_q.push_back(e);
      if (i < n_wr) begin
        w = ref_mem[widx(a)];
        a = d + 32'(4 * i);
        ref_mem[widx(a)] = w;
        e.kind = 1; e.addr = a; e.data = w;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    src_addr = s; dst_addr = d; word_cnt = CNT_W'(n);
    start = 1'b1; abort = sa;
    c = cyc; dc0 = done_count;
    e.kind = 2; e.addr = 32'd0; e.data = 32'd0; e.err = e_err; e.wd = CNT_W'(n_wr);
    e.cyc = c + 1 + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    src_addr = $urandom(); dst_addr = $urandom(); word_cnt = CNT_W'($urandom());
    t = 0;
    while (done_count == dc0 && t < 400) begin
      @(negedge clk);
      #1;
      t++;
      cy = cyc - c;
      abort = (ab > 0 && cy == ab) ? 1'b1 : 1'b0;
      start = (junk && lat >= 3 && cy == 2) ? 1'b1 : 1'b0;
    end
    start = 1'b0; abort = 1'b0;
    if (done_count == dc0) chk("done_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("err_held", 64'(err), 64'(e_err));
    chk("words_held", 64'(words_done), 64'(n_wr));
    chk("idle_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 256; i++) chk($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pat [4];
    logic [31:0] s, d, w1, w2;
    exp_t e;
    int c, n, ab;
    pat[0] = 32'h000000A1; pat[1] = 32'h000000B2;
    pat[2] = 32'h000000C3; pat[3] = 32'h000000D4;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      fill_idx  = 8'(i);
      fill_data = (i >= 16 && i < 20) ? pat[i - 16] : $urandom();
      ref_mem[i] = fill_data;
    end
    @(negedge clk);
    fill_en = 1'b0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_words", 64'(words_done), 64'd0);
    chk("rst_rd", 64'(bus.mem_rd), 64'd0);
    chk("rst_wr", 64'(bus.mem_wr), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    do_copy(32'h40, 32'h80, 4, 0, 1'b0, 1'b0);          // basic 4-word copy
    do_copy(32'h10, 32'h20, 0, 0, 1'b0, 1'b0);          // zero count
    do_copy(32'h42, 32'h80, 3, 0, 1'b0, 1'b0);          // misaligned source
    do_copy(32'hC0, 32'h1F0, 2, 0, 1'b0, 1'b0);         // clears err
    do_copy(32'h80, 32'h82, 0, 0, 1'b0, 1'b0);          // misaligned beats zero count
    do_copy(32'h200, 32'h300, 8, 6, 1'b0, 1'b0);        // abort in 3rd WRITE
    do_copy(32'h80, 32'h10, 5, 5, 1'b0, 1'b0);          // abort in 3rd READ
    do_copy(32'hFFFFFFF8, 32'h100, 3, 0, 1'b0, 1'b0);   // source wrap
    do_copy(32'h40, 32'h44, 5, 0, 1'b1, 1'b0);          // overlap dst>src, start ignored mid-flight

    // Reset during the WRITE of word 2: only word 1 reaches memory.
    w1 = ref_mem[widx(32'h300)];
    ref_mem[widx(32'h380)] = w1;
    w2 = ref_mem[widx(32'h304)];
    e.err = 1'b0; e.wd = '0; e.cyc = 0;
    e.kind = 0; e.addr = 32'h300; e.data = 32'd0; exp_q.push_back(e);
    e.kind = 1; e.addr = 32'h380; e.data = w1;    exp_q.push_back(e);
    e.kind = 0; e.addr = 32'h304; e.data = 32'd0; exp_q.push_back(e);
    e.kind = 1; e.addr = 32'h384; e.data = w2;    exp_q.push_back(e);
    @(negedge clk);
    src_addr = 32'h300; dst_addr = 32'h380; word_cnt = CNT_W'(4); start = 1'b1;
    c = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_words", 64'(words_done), 64'd0);
    chk("arst_rd", 64'(bus.mem_rd), 64'd0);
    chk("arst_wr", 64'(bus.mem_wr), 64'd0);
    chk("arst_addr", 64'(bus.mem_addr), 64'd0);
    chk("arst_wdata", 64'(bus.mem_wdata), 64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    chk("arst_queue", 64'(exp_q.size()), 64'd0);
    chk("arst_cycles", 64'(cyc - c), 64'd5);
    for (int i = 0; i < 256; i++) chk($sformatf("arst_mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));

    do_copy(32'h20, 32'h60, 2, 0, 1'b0, 1'b1);          // start with abort: start wins

    for (int k = 0; k < 12; k++) begin
      s = $urandom() & 32'hFFFFFFFC;
      if ($urandom_range(0, 2) == 0) d = s + 32'(4 * $urandom_range(1, 3));
      else d = $urandom() & 32'hFFFFFFFC;
      if ($urandom_range(0, 7) == 0) d = d | 32'd1;
      n  = $urandom_range(0, 10);
      ab = ($urandom_range(0, 3) == 0 && n > 0) ? $urandom_range(1, 2 * n) : 0;
      do_copy(s, d, n, ab, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
